// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter for four requesters that drives a registered 4:1 mux select.
// Each grant tenure lasts at most HOLD_MAX cycles.
module mux_4x1_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       valid,
    output logic       y
);

    localparam logic [3:0] HOLD_CNT = 4'(HOLD_MAX);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] sel, sel_nxt;
    logic [3:0] gnt_nxt;
    logic       valid_nxt;
    logic [1:0] search_start;
    logic [2:0] pick;

    // Returns {found, index} for the first set bit of r, searching from start upward (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            cand = start + 2'(i);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    // While granted, the search for a successor begins just past the current owner.
    assign search_start = (state == GRANT) ? sel + 2'd1 : ptr;
    assign pick         = rr_pick(req, search_start);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        valid_nxt = valid;
        case (state)
            IDLE: begin
                if (pick[2]) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick[1:0];
                    gnt_nxt   = 4'b0001 << pick[1:0];
                    valid_nxt = 1'b1;
                    cnt_nxt   = 4'd1;
                end else begin
                    gnt_nxt   = 4'b0000;
                    valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (req[sel] && (cnt < HOLD_CNT)) begin
                    cnt_nxt = cnt + 4'd1;
                end else begin
                    ptr_nxt = sel + 2'd1;
                    if (pick[2]) begin
                        sel_nxt = pick[1:0];
                        gnt_nxt = 4'b0001 << pick[1:0];
                        cnt_nxt = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        valid_nxt = 1'b0;
                        cnt_nxt   = 4'd0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
            sel   <= 2'd0;
            gnt   <= 4'b0000;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            gnt   <= gnt_nxt;
            valid <= valid_nxt;
        end
    end

    assign s1 = sel[1];
    assign s0 = sel[0];
    assign y  = valid & d[sel];

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Directed bench for mux_4x1_rr_arbiter with HOLD_MAX = 4.
// Expected values are written out by hand from the arbitration rules.
module tb_mux_4x1_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       valid;
    logic       y;

    int n_checks = 0;
    int n_errors = 0;

    mux_4x1_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d     (d),
        .gnt   (gnt),
        .s1    (s1),
        .s0    (s0),
        .valid (valid),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input int idx, input logic exp_y);
        check({tag, " gnt"},   32'(gnt), 32'(4'b0001 << idx));
        check({tag, " sel"},   32'({s1, s0}), 32'(idx));
        check({tag, " valid"}, 32'(valid), 32'd1);
        check({tag, " y"},     32'(y), 32'(exp_y));
    endtask

    task automatic check_idle(input string tag, input logic [1:0] exp_sel);
        check({tag, " gnt"},   32'(gnt), 32'd0);
        check({tag, " valid"}, 32'(valid), 32'd0);
        check({tag, " y"},     32'(y), 32'd0);
        check({tag, " sel"},   32'({s1, s0}), 32'(exp_sel));
    endtask

    initial begin
        int seq [5];
        logic [3:0] dv;
        seq = '{0, 1, 2, 3, 0};

        // Reset state
        rst = 1'b1;
        req = 4'b0000;
        d   = 4'b1101;
        #12;
        check_idle("reset", 2'd0);

        // All requesting from reset: 0,1,2,3,0, four cycles each, y follows d = 1101
        rst = 1'b0;
        req = 4'b1111;
        dv  = 4'b1101;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                check_grant($sformatf("rr g%0d c%0d", g, c), seq[g], dv[seq[g]]);
            end
        end

        // Asynchronous reset mid-grant, then req = 1000 from ptr = 0
        #2;
        rst = 1'b1;
        #1;
        check_idle("async rst", 2'd0);
        rst = 1'b0;
        req = 4'b1000;
        d   = 4'b1000;
        step();
        check_grant("after rst", 3, 1'b1);

        // Sole requester drops: back to idle, select holds
        req = 4'b0000;
        step();
        check_idle("idle ret", 2'd3);
        step();
        check_idle("idle hold", 2'd3);

        // Single requester 1 held: continuous grant across re-grant boundaries
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req = 4'b0010;
        d   = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            step();
            check_grant($sformatf("single c%0d", c), 1, 1'b1);
        end

        // Early release: req 0101, requester 0 drops after 2 cycles, requester 2 follows
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req = 4'b0101;
        d   = 4'b0100;
        step();
        check_grant("early c0", 0, 1'b0);
        step();
        check_grant("early c1", 0, 1'b0);
        req = 4'b0100;
        step();
        check_grant("early next", 2, 1'b1);

        // Owner 2 drops while 0 and 1 request: search from 3 wraps to 0
        req = 4'b0011;
        step();
        check_grant("wrap", 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux_4x1_rr_arbiter.md
MUX_4X1_RR_ARBITER -- requirements
Module: mux_4x1_rr_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 4, meaning the maximum consecutive grant cycles per tenure (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port req, input, 4 bits: request, bit i from requester i.
REQ-005 SHALL have port d, input, 4 bits: data bit of requester i (d[0]..d[3] map to mux inputs d0..d3).
REQ-006 SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-007 SHALL have port s1, output, 1 bit: mux select MSB, registered.
REQ-008 SHALL have port s0, output, 1 bit: mux select LSB, registered.
REQ-009 SHALL have port valid, output, 1 bit: high while any grant is active, registered.
REQ-010 SHALL have port y, output, 1 bit: selected data, combinational.

Function
REQ-011 SHALL implement two states: IDLE (no grant) and GRANT (one requester owns the mux).
REQ-012 SHALL hold a 2-bit round-robin pointer ptr; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 In IDLE with req != 0 at a rising edge, SHALL grant the first asserted requester in search order, enter GRANT, set cnt = 1; grant is visible 1 cycle after req is sampled.
REQ-014 In IDLE with req == 0, SHALL stay in IDLE with gnt = 0, valid = 0, and s1/s0 unchanged.
REQ-015 In GRANT, {s1,s0} SHALL equal the binary index of the granted requester, gnt SHALL be one-hot at that index, and valid SHALL be 1.
REQ-016 In GRANT, if req[idx] = 1 and cnt < HOLD_MAX, SHALL keep the grant and increment cnt (4-bit, saturating at HOLD_MAX).
REQ-017 In GRANT, SHALL release when req[idx] = 0 or cnt == HOLD_MAX; on release, ptr <= idx+1 mod 4.
REQ-018 On release with any other req asserted, SHALL grant the next requester in search order from idx+1 on the same edge (back-to-back, no IDLE cycle), with cnt = 1.
REQ-019 On release by cnt == HOLD_MAX with only req[idx] asserted, SHALL re-grant idx with cnt = 1 and ptr = idx+1.
REQ-020 On release with req == 0, SHALL enter IDLE; gnt and valid drop to 0 on that edge.
REQ-021 y SHALL equal d[{s1,s0}] when valid = 1, and 0 when valid = 0.
REQ-022 gnt SHALL never have more than one bit set; the arbiter SHALL never assert a grant for a requester whose req was 0 at the sampling edge.
REQ-023 Requests from non-owners SHALL not pre-empt a grant before release per REQ-017.

Reset
REQ-024 rst = 1 SHALL immediately, without waiting for clk, force state = IDLE, gnt = 0, s1 = 0, s0 = 0, valid = 0, ptr = 0, cnt = 0, hence y = 0.
REQ-025 Reset asserted mid-grant SHALL abort the tenure; after rst falls, the first grant SHALL follow REQ-013 with ptr = 0.

Verification
REQ-026 Reset: pulse rst between clock edges while granted -> gnt = 0, valid = 0, s1 = s0 = 0 immediately; after release, req = 4'b1000 -> gnt = 4'b1000, s1 = 1, s0 = 1 one cycle later.
REQ-027 Single requester, HOLD_MAX = 4, req = 4'b0010 held with d = 4'b0010 -> gnt = 4'b0010, s1 = 0, s0 = 1, y = 1; re-grant after 4 cycles; valid stays 1 throughout.
REQ-028 All requesting, req = 4'b1111 held from reset -> grants 0,1,2,3,0 in order, each lasting 4 cycles, with no gap cycle between them.
REQ-029 Early release: req = 4'b0101, requester 0 drops req after 2 granted cycles -> requester 2 is granted on the next edge, ptr = 1, s1 = 1, s0 = 0.
REQ-030 Idle return: the sole requester drops req -> gnt = 0, valid = 0, y = 0 next cycle; s1/s0 hold their last value.
REQ-031 Data path, d = 4'b1101 (d0 = 1, d1 = 0, d2 = 1, d3 = 1) with grants stepping through indices 0,1,2,3 -> y = 1, 0, 1, 1 respectively.
